// File: rtl/cell_painter_pkg.sv
// Shared board geometry, colour palette and draw-mode encodings for the
// game datapath, board drawing, score logic and the cell painter.
package cell_painter_pkg;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'b00,
        MODE_OUTLINE = 2'b01,
        MODE_PIECE   = 2'b10,
        MODE_CLEAR   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAW = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // 3-bit RGB palette used by the VGA adapter
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [2:0] HIGHLIGHT_MOVE   = YELLOW;
    localparam logic [2:0] HIGHLIGHT_SELECT = RED;

    localparam int BOARD_CELL_PX  = 14;
    localparam int BOARD_ORIGIN_X = 24;
    localparam int BOARD_ORIGIN_Y = 4;
    localparam int SCREEN_W       = 160;
    localparam int SCREEN_H       = 120;

    typedef struct packed {
        logic [2:0] cellX;
        logic [2:0] cellY;
        logic [2:0] colour;
        mode_e      mode;
    } cell_req_t;

endpackage

// File: rtl/cell_pixel_shader.sv
// Combinational per-pixel colour/plot decision for one cell, given the
// pixel's position (col, row) inside the cell square and the draw mode.
module cell_pixel_shader
    import cell_painter_pkg::*;
#(
    parameter int         CELL_PX      = BOARD_CELL_PX,
    parameter logic [2:0] GRID_COLOUR  = BLACK,
    parameter logic [2:0] BOARD_COLOUR = GREEN,
    localparam int        CW           = $clog2(CELL_PX)
) (
    input  logic [CW-1:0] col_i,
    input  logic [CW-1:0] row_i,
    input  mode_e         mode_i,
    input  logic [2:0]    colour_i,
    output logic [2:0]    pixColour_o,
    output logic          pixPlot_o
);

    localparam logic [CW-1:0] LAST = CW'(CELL_PX - 1);

    logic [CW-1:0] colRev, rowRev, colDist, rowDist, inset;

    // inset is the distance to the nearest cell edge; 0 means a grid-line pixel
    always_comb begin
        colRev  = LAST - col_i;
        rowRev  = LAST - row_i;
        colDist = (col_i < colRev) ? col_i : colRev;
        rowDist = (row_i < rowRev) ? row_i : rowRev;
        inset   = (colDist < rowDist) ? colDist : rowDist;
    end

    always_comb begin
        pixPlot_o   = 1'b1;
        pixColour_o = colour_i;
        case (mode_i)
            MODE_FILL: begin
                pixColour_o = colour_i;
            end
            MODE_OUTLINE: begin
                pixPlot_o = (inset == '0);
            end
            MODE_PIECE: begin
                if (inset == '0)
                    pixColour_o = GRID_COLOUR;
                else if (inset <= CW'(2))
                    pixColour_o = BOARD_COLOUR;
                else
                    pixColour_o = colour_i;
            end
            MODE_CLEAR: begin
                pixColour_o = (inset == '0) ? GRID_COLOUR : BOARD_COLOUR;
            end
            default: begin
                pixPlot_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cell_painter.sv
// Expands one board-cell draw request into a raster of single-pixel VGA
// plot writes, one per cycle, with busy/done handshaking to the datapath.
module cell_painter
    import cell_painter_pkg::*;
#(
    parameter int         CELL_PX      = BOARD_CELL_PX,
    parameter int         ORIGIN_X     = BOARD_ORIGIN_X,
    parameter int         ORIGIN_Y     = BOARD_ORIGIN_Y,
    parameter logic [2:0] GRID_COLOUR  = BLACK,
    parameter logic [2:0] BOARD_COLOUR = GREEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] cell_x,
    input  logic [2:0] cell_y,
    input  logic [2:0] colour,
    input  logic [1:0] mode,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int            CW   = $clog2(CELL_PX);
    localparam logic [CW-1:0] LAST = CW'(CELL_PX - 1);

    // The board must fit on screen so the 8/7-bit address adders never wrap
    if (CELL_PX < 2 || 8 * CELL_PX > SCREEN_H ||
        ORIGIN_X + 8 * CELL_PX > SCREEN_W || ORIGIN_Y + 8 * CELL_PX > SCREEN_H) begin : g_bad_geometry
        $error("cell_painter: board geometry does not fit the 160x120 screen");
    end

    state_e        state_q, state_d;
    cell_req_t     req_q, req_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d;
    logic [7:0]    vgaX_q, vgaX_d;
    logic [6:0]    vgaY_q, vgaY_d;
    logic [2:0]    vgaColour_q, vgaColour_d;
    logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [7:0]    pixX;
    logic [6:0]    pixY;
    logic [2:0]    pixColour;
    logic          pixPlot;

    assign pixX = 8'(ORIGIN_X) + 8'(req_q.cellX) * 8'(CELL_PX) + 8'(i_q);
    assign pixY = 7'(ORIGIN_Y) + 7'(req_q.cellY) * 7'(CELL_PX) + 7'(j_q);

    cell_pixel_shader #(
        .CELL_PX      (CELL_PX),
        .GRID_COLOUR  (GRID_COLOUR),
        .BOARD_COLOUR (BOARD_COLOUR)
    ) u_shader (
        .col_i       (i_q),
        .row_i       (j_q),
        .mode_i      (req_q.mode),
        .colour_i    (req_q.colour),
        .pixColour_o (pixColour),
        .pixPlot_o   (pixPlot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            vgaX_q      <= '0;
            vgaY_q      <= '0;
            vgaColour_q <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            i_q         <= i_d;
            j_q         <= j_d;
            vgaX_q      <= vgaX_d;
            vgaY_q      <= vgaY_d;
            vgaColour_q <= vgaColour_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAW;
                    req_d   = '{cellX: cell_x, cellY: cell_y, colour: colour, mode: mode_e'(mode)};
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_DRAW: begin
                if (i_q == LAST) begin
                    i_d = '0;
                    if (j_q == LAST)
                        state_d = ST_DONE;
                    else
                        j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; colour holds on unplotted pixels
    always_comb begin
        vgaX_d      = vgaX_q;
        vgaY_d      = vgaY_q;
        vgaColour_d = vgaColour_q;
        plot_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: busy_d = start;
            ST_DRAW: begin
                vgaX_d = pixX;
                vgaY_d = pixY;
                plot_d = pixPlot;
                if (pixPlot)
                    vgaColour_d = pixColour;
            end
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign vga_x      = vgaX_q;
    assign vga_y      = vgaY_q;
    assign vga_colour = vgaColour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
